// File: rtl/booth_pkg.sv
// Shared types and sizes for the sequential radix-4 Booth multiplier.
package booth_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam int NDIG = 4;   // radix-4 digits in an 8-bit multiplier
   localparam int OPW  = 8;   // operand width
   localparam int PPW  = 11;  // partial product width (2a plus sign margin)
   localparam int PW   = 16;  // full product width

   // Operation selected by one Booth digit
   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_op_t;

   // Maps an overlapping 3-bit multiplier window onto its Booth operation
   function automatic booth_op_t booth_decode(input logic [2:0] d);
      booth_op_t op;
      case (d)
         3'b001, 3'b010: op = POS1;
         3'b011:         op = POS2;
         3'b100:         op = NEG2;
         3'b101, 3'b110: op = NEG1;
         default:        op = ZERO;  // 000 and 111
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// Combinational partial-product generator for one radix-4 Booth digit.
module booth_digit_pp
   import booth_pkg::*;
(
   input  logic [OPW-1:0]        a,
   input  logic [2:0]            digit,
   output logic signed [PPW-1:0] pp
);

   logic signed [PPW-1:0] a_ext;

   assign a_ext = $signed({{(PPW - OPW){a[OPW-1]}}, a});

   // Select 0, +-a or +-2a; 11 bits keep -(-2*128) = +256 exact
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pp = '0;
      case (booth_decode(digit))
         POS1:    pp = a_ext;
         POS2:    pp = a_ext <<< 1;
         NEG1:    pp = -a_ext;
         NEG2:    pp = -(a_ext <<< 1);
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth 8x8 signed multiplier: one digit per cycle into
// a 16-bit accumulator, valid/ready on operand and result sides.
// Optional rounded/saturated Q1.7 output q is built when FXP_ROUND_EN is defined.
module booth_seq_mult_ctrl
   import booth_pkg::*;
`ifdef FXP_ROUND_EN
#(
   parameter int FRAC_BITS = 7
)
`endif
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [PW-1:0]  p,
`ifdef FXP_ROUND_EN
   output logic [OPW-1:0] q,
`endif
   output logic           busy
);

   localparam int CW = $clog2(NDIG);

   state_t                state, state_next;
   logic [CW-1:0]         cnt;
   logic [OPW-1:0]        a_r;
   logic [OPW:0]          b_ext;
   logic [PW-1:0]         acc, acc_next, pp_ext, addend, p_r;
   logic [2:0]            digit;
   logic signed [PPW-1:0] pp;
   logic                  last_dig;

   booth_digit_pp u_pp (
      .a     (a_r),
      .digit (digit),
      .pp    (pp)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign p         = p_r;
   assign last_dig  = (cnt == CW'(NDIG - 1));

   // Pick the overlapping 3-bit window b_ext[2*cnt+2 : 2*cnt]
   always_comb begin
      digit = b_ext[2:0];
      case (cnt)
         2'd1:    digit = b_ext[4:2];
         2'd2:    digit = b_ext[6:4];
         2'd3:    digit = b_ext[8:6];
         default: digit = b_ext[2:0];
      endcase
   end

   assign pp_ext   = {{(PW - PPW){pp[PPW-1]}}, pp};
   assign addend   = pp_ext << {cnt, 1'b0};
   assign acc_next = acc + addend;  // mod 2^16; the exact product always fits

`ifdef FXP_ROUND_EN
   localparam logic signed [PW:0] Q_MAX = (PW + 1)'(2 ** (OPW - 1) - 1);
   localparam logic signed [PW:0] Q_MIN = (PW + 1)'(-(2 ** (OPW - 1)));

   logic signed [PW:0] rnd_sum, rnd_shr;
   logic [OPW-1:0]     q_next, q_r;

   // Round half up, then saturate to the signed 8-bit range
   always_comb begin
      rnd_sum = $signed({acc_next[PW-1], acc_next}) + $signed((PW + 1)'(1 << (FRAC_BITS - 1)));
      rnd_shr = rnd_sum >>> FRAC_BITS;
      q_next  = rnd_shr[OPW-1:0];
      if (rnd_shr > Q_MAX) begin
         q_next = Q_MAX[OPW-1:0];
      end else if (rnd_shr < Q_MIN) begin
         q_next = Q_MIN[OPW-1:0];
      end
   end

   assign q = q_r;
`endif

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (last_dig) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, per-digit accumulation and result register
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, so a reset mid-operation leaves p cleared and no stale acc.
      if (rst) begin
         cnt   <= '0;
         a_r   <= '0;
         b_ext <= '0;
         acc   <= '0;
         p_r   <= '0;
`ifdef FXP_ROUND_EN
         q_r   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_ext <= {b, 1'b0};
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               acc <= acc_next;
               if (last_dig) begin
                  p_r <= acc_next;
`ifdef FXP_ROUND_EN
                  q_r <= q_next;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl: directed vector table,
// latency/backpressure/reset sequences and a random scoreboard run.
module tb_booth_seq_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        busy;
`ifdef FXP_ROUND_EN
   logic [7:0]  q;
`endif

   int n_vec = 0;
   int n_err = 0;

   booth_seq_mult_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
`ifdef FXP_ROUND_EN
      .q         (q),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      logic [7:0]  q;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   // One full transaction with out_ready held high; called on a negedge in IDLE.
   task automatic run_vector(input logic [7:0] va, input logic [7:0] vb,
                             output logic ok, output logic [15:0] gp, output logic [7:0] gq);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      in_valid  = 1'b1;
      a         = va;
      b         = vb;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~va;
      b        = ~vb;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = out_valid;
      gp = p;
`ifdef FXP_ROUND_EN
      gq = q;
`else
      gq = 8'h00;
`endif
      @(negedge clk);
   endtask

   initial begin
      logic        ok;
      logic [15:0] gp;
      logic [7:0]  gq;
      int          cyc;
      int          issued, received;
      logic        pend;
      logic [15:0] sb[$];
      logic [15:0] exp_p;

      // a, b, p, q = sat((p + 64) >>> 7)
      vecs[0]  = '{8'h03, 8'h05, 16'h000F, 8'h00};
      vecs[1]  = '{8'h80, 8'h80, 16'h4000, 8'h7F};
      vecs[2]  = '{8'h80, 8'h7F, 16'hC080, 8'h81};
      vecs[3]  = '{8'h7F, 8'h7F, 16'h3F01, 8'h7E};
      vecs[4]  = '{8'h00, 8'hFF, 16'h0000, 8'h00};
      vecs[5]  = '{8'hF9, 8'h09, 16'hFFC1, 8'h00};
      vecs[6]  = '{8'h01, 8'hFF, 16'hFFFF, 8'h00};
      vecs[7]  = '{8'hFF, 8'hFF, 16'h0001, 8'h00};
      vecs[8]  = '{8'h40, 8'h40, 16'h1000, 8'h20};
      vecs[9]  = '{8'h01, 8'h40, 16'h0040, 8'h01};
      vecs[10] = '{8'h80, 8'h01, 16'hFF80, 8'hFF};
      vecs[11] = '{8'h55, 8'hAA, 16'hE372, 8'hC7};
      vecs[12] = '{8'h80, 8'hFF, 16'h0080, 8'h01};
      vecs[13] = '{8'h7F, 8'h80, 16'hC080, 8'h81};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'h00;
      b         = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_p", p, 0);
`ifdef FXP_ROUND_EN
      check("rst_q", q, 0);
`endif

      // Latency: accept edge is cycle 0, out_valid visible in cycle 5
      in_valid  = 1'b1;
      a         = 8'd3;
      b         = 8'd5;
      out_ready = 1'b1;
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b0;
         if (cyc == 1) check("lat_busy_calc", busy, 1);
      end while (!out_valid && cyc < 20);
      check("lat_cycles", cyc, 5);
      check("lat_p", p, 16'd15);
      @(negedge clk);
      check("lat_in_ready_after", in_ready, 1);
      check("lat_out_valid_after", out_valid, 0);

      // Directed table
      for (int i = 0; i < 14; i++) begin
         run_vector(vecs[i].a, vecs[i].b, ok, gp, gq);
         check($sformatf("vec%0d_valid", i), ok, 1);
         check($sformatf("vec%0d_p", i), gp, vecs[i].p);
`ifdef FXP_ROUND_EN
         check($sformatf("vec%0d_q", i), gq, vecs[i].q);
`endif
      end

      // Backpressure with a spurious in_valid during CALC and DONE
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 8'h80;
      b         = 8'h7F;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         check("bp_in_ready_calc", in_ready, 0);
         in_valid = (cyc == 1);
         a        = 8'h01;
         b        = 8'h01;
         @(negedge clk);
         cyc++;
      end
      for (int k = 0; k < 3; k++) begin
         check("bp_out_valid_hold", out_valid, 1);
         check("bp_p_hold", p, 16'hC080);
         check("bp_in_ready_done", in_ready, 0);
         in_valid = (k == 1);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_p_release", p, 16'hC080);
      @(negedge clk);
      check("bp_idle_busy", busy, 0);
      check("bp_idle_p_hold", p, 16'hC080);
      repeat (6) @(negedge clk);
      check("bp_no_phantom", out_valid, 0);

      // Reset during the 2nd CALC cycle
      in_valid = 1'b1;
      a        = 8'h05;
      b        = 8'h05;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("rm_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rm_in_ready", in_ready, 1);
      check("rm_out_valid", out_valid, 0);
      check("rm_busy", busy, 0);
      check("rm_p", p, 0);
`ifdef FXP_ROUND_EN
      check("rm_q", q, 0);
`endif
      run_vector(8'hF9, 8'h09, ok, gp, gq);
      check("rm_next_valid", ok, 1);
      check("rm_next_p", gp, 16'hFFC1);

      // Random regression with stalls, scoreboard in order
      issued   = 0;
      received = 0;
      pend     = 1'b0;
      cyc      = 0;
      in_valid = 1'b0;
      while (received < 1000 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (!pend && issued < 1000 && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            a    = 8'($urandom);
            b    = 8'($urandom);
         end
         in_valid  = pend;
         out_ready = ($urandom_range(0, 2) != 0);
         if (in_valid && in_ready) begin
            exp_p = 16'(int'($signed(a)) * int'($signed(b)));
            sb.push_back(exp_p);
            pend = 1'b0;
            issued++;
         end
         if (out_valid && out_ready) begin
            check("rand_sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) check($sformatf("rand%0d_p", received), p, sb.pop_front());
            received++;
         end
      end
      in_valid = 1'b0;
      check("rand_results", received, 1000);
      check("rand_leftover", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
